// File: rtl/lat_tester_ctrl.sv
// ============================================================================
// lat_tester_ctrl
//
// Sequencer for the latency-test pattern of the 720x480 test-pattern
// generator. A start request waits for a frame boundary (falling VSYNC),
// enables the pattern on the generator, and counts clk27 cycles until the
// photodiode comparator reports light. The pattern is then released and the
// block waits for the sensor to stay dark before reporting the result.
// This block is the only driver of the generator's lt_active/lt_mode inputs.
//
// Optional build macro:
//   LT_AVG_EN  - each start runs four measurements back-to-back and reports
//                their average (sum >> 2). A timeout in any measurement ends
//                the sequence with an all-ones result and the timeout flag.
//                Without the macro, one measurement is made per start.
//
// Parameters:
//   LAT_W        latency counter / result width
//   TIMEOUT_CYC  cycles allowed in WAIT_FRAME or MEASURE (must be < 2**LAT_W)
//   SETTLE_CYC   consecutive dark cycles required before reporting
//
// Ports:
//   clk27      in   27 MHz pixel clock
//   reset      in   asynchronous active-high reset
//   start      in   request pulse, honoured only while idle
//   mode_sel   in   [1:0] pattern position code, 2'b00 is invalid
//   vsync_in   in   generator VSYNC (negative polarity, clk27 domain)
//   sensor_in  in   photodiode comparator, asynchronous, 1 = light
//   lt_active  out  pattern enable to the generator
//   lt_mode    out  [1:0] pattern position to the generator
//   busy       out  high whenever a sequence is in progress
//   done       out  one-cycle completion pulse
//   timeout    out  sticky error flag, cleared by an accepted start
//   latency    out  [LAT_W-1:0] last result in clk27 cycles, all-ones on timeout
// ============================================================================
module lat_tester_ctrl #(
    parameter int LAT_W       = 22,
    parameter int TIMEOUT_CYC = 2700000,
    parameter int SETTLE_CYC  = 27000
) (
    input  logic             clk27,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode_sel,
    input  logic             vsync_in,
    input  logic             sensor_in,
    output logic             lt_active,
    output logic [1:0]       lt_mode,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [LAT_W-1:0] latency
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int DARK_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [LAT_W-1:0]  CNT_LAST  = LAT_W'(TIMEOUT_CYC - 1);
    localparam logic [DARK_W-1:0] DARK_LAST = DARK_W'(SETTLE_CYC - 1);
    localparam logic [LAT_W-1:0]  CNT_ONE   = LAT_W'(1);
    localparam logic [DARK_W-1:0] DARK_ONE  = DARK_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]        state_q,   state_d;
    logic [LAT_W-1:0]  cnt_q,     cnt_d;
    logic [DARK_W-1:0] dark_q,    dark_d;
    logic              active_q,  active_d;
    logic [1:0]        mode_q,    mode_d;
    logic              timeout_q, timeout_d;
    logic [LAT_W-1:0]  lat_q,     lat_d;
`ifdef LT_AVG_EN
    logic [LAT_W+1:0]  acc_q,     acc_d;
    logic [1:0]        nmeas_q,   nmeas_d;
`endif

    // Input conditioning: sensor_in is asynchronous and goes through two
    // flops; vsync_in is already in this clock domain but is registered
    // twice so that the edge detector works on flopped values only.
    logic sens_meta_q;
    logic sens_s_q;
    logic vs_q;
    logic vs_prev_q;
    logic vs_fall;

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            sens_meta_q <= 1'b0;
            sens_s_q    <= 1'b0;
            // VSYNC idles high; resetting to 1 avoids a false edge after reset.
            vs_q        <= 1'b1;
            vs_prev_q   <= 1'b1;
        end else begin
            sens_meta_q <= sensor_in;
            sens_s_q    <= sens_meta_q;
            vs_q        <= vsync_in;
            vs_prev_q   <= vs_q;
        end
    end

    assign vs_fall = vs_prev_q & ~vs_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dark_d    = dark_q;
        active_d  = active_q;
        mode_d    = mode_q;
        timeout_d = timeout_q;
        lat_d     = lat_q;
`ifdef LT_AVG_EN
        acc_d     = acc_q;
        nmeas_d   = nmeas_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && (mode_sel != 2'b00)) begin
                    mode_d    = mode_sel;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
`ifdef LT_AVG_EN
                    acc_d     = '0;
                    nmeas_d   = 2'd0;
`endif
                end
            end

            S_WAIT: begin
                // A frame edge seen while the sensor is still lit is skipped,
                // otherwise the pattern would start on a stale light reading.
                if (vs_fall && !sens_s_q) begin
                    cnt_d    = '0;
                    active_d = 1'b1;
                    state_d  = S_MEASURE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_MEASURE: begin
                // A hit wins over a timeout landing in the same cycle.
                if (sens_s_q) begin
                    active_d = 1'b0;
                    dark_d   = '0;
                    state_d  = S_RELEASE;
`ifdef LT_AVG_EN
                    acc_d    = acc_q + {2'b00, cnt_q};
`else
                    lat_d    = cnt_q;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_FAIL: begin
                lat_d     = '1;
                timeout_d = 1'b1;
                active_d  = 1'b0;
                dark_d    = '0;
                state_d   = S_RELEASE;
            end

            S_RELEASE: begin
                // Any light reading restarts the dark-settle window.
                if (sens_s_q) begin
                    dark_d = '0;
                end else if (dark_q == DARK_LAST) begin
`ifdef LT_AVG_EN
                    if (timeout_q || (nmeas_q == 2'd3)) begin
                        // Average is written on the way into DONE so it is
                        // already stable while done is high.
                        if (!timeout_q) begin
                            lat_d = acc_q[LAT_W+1:2];
                        end
                        state_d = S_DONE;
                    end else begin
                        nmeas_d = nmeas_q + 2'd1;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
`else
                    state_d = S_DONE;
`endif
                end else begin
                    dark_d = dark_q + DARK_ONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dark_q    <= '0;
            active_q  <= 1'b0;
            mode_q    <= 2'b00;
            timeout_q <= 1'b0;
            lat_q     <= '0;
`ifdef LT_AVG_EN
            acc_q     <= '0;
            nmeas_q   <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dark_q    <= dark_d;
            active_q  <= active_d;
            mode_q    <= mode_d;
            timeout_q <= timeout_d;
            lat_q     <= lat_d;
`ifdef LT_AVG_EN
            acc_q     <= acc_d;
            nmeas_q   <= nmeas_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all derived from flopped state)
    // ------------------------------------------------------------------
    assign lt_active = active_q;
    assign lt_mode   = mode_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign timeout   = timeout_q;
    assign latency   = lat_q;

endmodule

// File: tb/tb_lat_tester_ctrl.sv
module tb_lat_tester_ctrl;

    localparam int LAT_W     = 22;
    localparam int TO        = 1000;
    localparam int SETTLE    = 4;
    localparam int VS_PERIOD = 200;

    logic             clk27    = 1'b0;
    logic             reset    = 1'b0;
    logic             start    = 1'b0;
    logic [1:0]       mode_sel = 2'b00;
    logic             vsync_in = 1'b1;
    logic             sensor_in = 1'b0;
    logic             lt_active;
    logic [1:0]       lt_mode;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [LAT_W-1:0] latency;

    int total = 0;
    int bad   = 0;
    int pcyc  = 0;
    int vs_drop_p = -1;

    lat_tester_ctrl #(
        .LAT_W       (LAT_W),
        .TIMEOUT_CYC (TO),
        .SETTLE_CYC  (SETTLE)
    ) dut (
        .clk27     (clk27),
        .reset     (reset),
        .start     (start),
        .mode_sel  (mode_sel),
        .vsync_in  (vsync_in),
        .sensor_in (sensor_in),
        .lt_active (lt_active),
        .lt_mode   (lt_mode),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .latency   (latency)
    );

    always #5 clk27 = ~clk27;

    always @(posedge clk27) pcyc <= pcyc + 1;

    // VSYNC: low for 3 cycles at the start of every 200-cycle frame.
    always @(negedge clk27) begin
        if (pcyc % VS_PERIOD == 0) begin
            vsync_in  = 1'b0;
            vs_drop_p = pcyc;
        end else if (pcyc % VS_PERIOD == 3) begin
            vsync_in = 1'b1;
        end
    end

    // ---------------- reference model ----------------
    // Result seen by the host: sensor delay plus the two synchronizer cycles,
    // unless that count would reach the timeout limit first.
    function automatic bit model_hit(input int d);
        return (d >= 0) && (d + 2 <= TO - 1);
    endfunction

    function automatic logic [LAT_W-1:0] model_lat(input int d);
        if (model_hit(d)) return LAT_W'(d + 2);
        return '1;
    endfunction

    // Pattern is visible from the first MEASURE cycle up to and including the
    // cycle in which the hit (or the FAIL state) is processed.
    function automatic int model_act(input int d);
        if (model_hit(d)) return d + 3;
        return TO + 1;
    endfunction

    // done follows SETTLE dark synchronized cycles that begin after both the
    // pattern has dropped and the last light sample has left the synchronizer.
    function automatic int model_done_k(input int last_act_k, input int last_hi_k);
        int a;
        int b;
        a = last_act_k + 1 + SETTLE;
        b = last_hi_k + 3 + SETTLE;
        return (a > b) ? a : b;
    endfunction

    typedef struct {
        bit         fin;
        logic       busy0;
        int         t0;
        int         rise_gap;
        int         drop_p;
        int         dark_p;
        int         act_cyc;
        int         last_act_k;
        int         last_hi_k;
        int         done_cnt;
        int         done_k;
    } obs_t;

    // Drives one start/measure/release sequence and records what was seen.
    // d<0: sensor never lights. After the hit the sensor stays lit for 'hold'
    // cycles, then follows 'pat' (MSB first), then stays dark.
    task automatic run_meas(input logic [1:0] m, input int d, input int hold,
                            input logic [7:0] pat, input int pre_light, output obs_t o);
        int j;
        logic s;
        logic [1:0] other;
        o.fin = 0; o.busy0 = 1'b0; o.t0 = -1; o.rise_gap = -1; o.drop_p = -1;
        o.dark_p = -1; o.act_cyc = 0; o.last_act_k = -1; o.last_hi_k = -100;
        o.done_cnt = 0; o.done_k = -1;
        other = (m == 2'd3) ? 2'd1 : m + 2'd1;
        sensor_in = (pre_light > 0);
        repeat (4) @(negedge clk27);
        start = 1'b1; mode_sel = m;
        @(negedge clk27);
        start = 1'b0; mode_sel = 2'($urandom_range(0, 3));
        o.busy0 = busy;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk27);
            if (k == 3) begin start = 1'b1; mode_sel = other; end
            else if (k == 4) start = 1'b0;
            if (pre_light > 0 && k == pre_light) begin sensor_in = 1'b0; o.dark_p = pcyc; end
            if (lt_active) begin
                o.act_cyc++;
                o.last_act_k = k;
                if (o.t0 < 0) begin
                    o.t0 = k; o.rise_gap = pcyc - vs_drop_p; o.drop_p = vs_drop_p;
                end
            end
            if (done) begin
                o.done_cnt++;
                if (o.done_k < 0) o.done_k = k;
            end
            if (o.done_k >= 0 && k >= o.done_k + 3) begin o.fin = 1; break; end
            if (d >= 0 && o.t0 >= 0) begin
                j = k - (o.t0 + d);
                if (j >= 0) begin
                    if (j < hold) s = 1'b1;
                    else if (j < hold + 8) s = pat[7 - (j - hold)];
                    else s = 1'b0;
                    sensor_in = s;
                    if (s) o.last_hi_k = k;
                end
            end
        end
        start = 1'b0;
        sensor_in = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        total++; if (lt_active !== 1'b0) begin bad++; $display("FAIL reset_lt_active got=%b want=0", lt_active); end
        total++; if (lt_mode !== 2'b00) begin bad++; $display("FAIL reset_lt_mode got=%b want=00", lt_mode); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
        total++; if (latency !== '0) begin bad++; $display("FAIL reset_latency got=%0d want=0", latency); end
        repeat (3) @(negedge clk27);
        reset = 1'b0;
        repeat (3) @(negedge clk27);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_basic;
        obs_t o;
        run_meas(2'd2, 50, 5, 8'h00, 0, o);
        total++; if (!o.fin) begin bad++; $display("FAIL basic_finish got=none want=done"); end
        total++; if (o.busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", o.busy0); end
        total++; if (latency !== LAT_W'(52)) begin bad++; $display("FAIL basic_latency got=%0d want=52", latency); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b want=0", timeout); end
        total++; if (o.done_cnt != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", o.done_cnt); end
        total++; if (o.act_cyc != 53) begin bad++; $display("FAIL basic_active_cycles got=%0d want=53", o.act_cyc); end
        total++; if (o.rise_gap != 2) begin bad++; $display("FAIL basic_vsync_to_active got=%0d want=2", o.rise_gap); end
        total++; if (lt_mode !== 2'd2) begin bad++; $display("FAIL basic_lt_mode got=%0d want=2", lt_mode); end
        total++; if (o.done_k != model_done_k(o.last_act_k, o.last_hi_k)) begin bad++;
            $display("FAIL basic_done_time got=%0d want=%0d", o.done_k, model_done_k(o.last_act_k, o.last_hi_k)); end
        total++; if (busy !== 1'b0 || lt_active !== 1'b0) begin bad++;
            $display("FAIL basic_end_idle got=busy%b/act%b want=0/0", busy, lt_active); end
    endtask

    task automatic check_run(input string tag, input logic [1:0] m, input int d, input obs_t o);
        total++; if (!o.fin) begin bad++; $display("FAIL %s_finish d=%0d got=none want=done", tag, d); end
        total++; if (latency !== model_lat(d)) begin bad++;
            $display("FAIL %s_latency d=%0d got=%0h want=%0h", tag, d, latency, model_lat(d)); end
        total++; if (timeout !== !model_hit(d)) begin bad++;
            $display("FAIL %s_timeout d=%0d got=%b want=%b", tag, d, timeout, !model_hit(d)); end
        total++; if (o.act_cyc != model_act(d)) begin bad++;
            $display("FAIL %s_active_cycles d=%0d got=%0d want=%0d", tag, d, o.act_cyc, model_act(d)); end
        total++; if (o.done_cnt != 1) begin bad++; $display("FAIL %s_done_pulses d=%0d got=%0d want=1", tag, d, o.done_cnt); end
        total++; if (lt_mode !== m) begin bad++; $display("FAIL %s_lt_mode d=%0d got=%0d want=%0d", tag, d, lt_mode, m); end
        total++; if (o.rise_gap != 2) begin bad++; $display("FAIL %s_vsync_to_active d=%0d got=%0d want=2", tag, d, o.rise_gap); end
        total++; if (o.done_k != model_done_k(o.last_act_k, o.last_hi_k)) begin bad++;
            $display("FAIL %s_done_time d=%0d got=%0d want=%0d", tag, d, o.done_k, model_done_k(o.last_act_k, o.last_hi_k)); end
    endtask

    task automatic test_random;
        obs_t o;
        logic [1:0] m;
        int d;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 199)) @(negedge clk27);
            m = 2'($urandom_range(1, 3));
            d = $urandom_range(0, 1050);
            run_meas(m, d, $urandom_range(1, 20), 8'h00, 0, o);
            check_run("rand", m, d, o);
        end
    endtask

    task automatic test_boundary;
        obs_t o;
        run_meas(2'd1, 997, 3, 8'h00, 0, o);
        check_run("edge_hit", 2'd1, 997, o);
        run_meas(2'd3, 998, 3, 8'h00, 0, o);
        check_run("edge_timeout", 2'd3, 998, o);
    endtask

    task automatic test_timeout;
        obs_t o;
        run_meas(2'd2, -1, 0, 8'h00, 0, o);
        check_run("timeout", 2'd2, -1, o);
        total++; if (o.done_k - o.last_act_k != SETTLE + 1) begin bad++;
            $display("FAIL timeout_settle got=%0d want=%0d", o.done_k - o.last_act_k, SETTLE + 1); end
    endtask

    task automatic test_bad_start;
        logic [LAT_W-1:0] lat0;
        logic to0;
        logic [1:0] md0;
        int hits;
        lat0 = latency; to0 = timeout; md0 = lt_mode; hits = 0;
        @(negedge clk27);
        start = 1'b1; mode_sel = 2'b00;
        @(negedge clk27);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (busy !== 1'b0) hits++;
            @(negedge clk27);
        end
        total++; if (hits != 0) begin bad++; $display("FAIL badstart_busy got=%0d busy cycles want=0", hits); end
        total++; if (lt_mode !== md0) begin bad++; $display("FAIL badstart_lt_mode got=%0d want=%0d", lt_mode, md0); end
        total++; if (timeout !== to0 || latency !== lat0) begin bad++;
            $display("FAIL badstart_result got=%b/%0h want=%b/%0h", timeout, latency, to0, lat0); end
    endtask

    task automatic test_skip_lit_frame;
        obs_t o;
        while (pcyc % VS_PERIOD != 10) @(negedge clk27);
        run_meas(2'd1, 60, 2, 8'h00, 250, o);
        check_run("skip", 2'd1, 60, o);
        total++; if (!(o.drop_p > o.dark_p && o.dark_p >= 0)) begin bad++;
            $display("FAIL skip_frame got=vsdrop%0d want=after_dark%0d", o.drop_p, o.dark_p); end
        total++; if (o.t0 < 250) begin bad++; $display("FAIL skip_active_early got=k%0d want=>=250", o.t0); end
    endtask

    task automatic test_release_toggle;
        obs_t o;
        run_meas(2'd3, 30, 3, 8'b1001_0000, 0, o);
        check_run("toggle", 2'd3, 30, o);
        total++; if (o.done_k - o.last_hi_k != SETTLE + 3) begin bad++;
            $display("FAIL toggle_settle got=%0d want=%0d", o.done_k - o.last_hi_k, SETTLE + 3); end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        repeat (3) @(negedge clk27);
        start = 1'b1; mode_sel = 2'd2;
        @(negedge clk27);
        start = 1'b0;
        for (int k = 0; k < 1500 && seen == 0; k++) begin
            @(negedge clk27);
            if (lt_active === 1'b1) seen = 1;
        end
        total++; if (seen != 1) begin bad++; $display("FAIL rstmid_active got=0 want=1"); end
        repeat (10) @(negedge clk27);
        #2 reset = 1'b1;
        #1;
        total++; if (lt_active !== 1'b0) begin bad++; $display("FAIL rstmid_lt_active got=%b want=0", lt_active); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (latency !== '0) begin bad++; $display("FAIL rstmid_latency got=%0d want=0", latency); end
        total++; if (lt_mode !== 2'b00 || timeout !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL rstmid_others got=%b/%b/%b want=00/0/0", lt_mode, timeout, done); end
        @(negedge clk27);
        reset = 1'b0;
        repeat (2) @(negedge clk27);
    endtask

`ifdef LT_AVG_EN
    task automatic test_avg;
        int ds[4];
        int n_rise;
        int t0;
        int done_cnt;
        int done_k;
        int sum;
        logic prev_act;
        logic [LAT_W-1:0] exp_l;
        ds = '{40, 42, 44, 46};
        sum = 0;
        for (int i = 0; i < 4; i++) sum += ds[i] + 2;
        exp_l = LAT_W'(sum / 4);
        n_rise = 0; t0 = -1; done_cnt = 0; done_k = -1; prev_act = 1'b0;
        sensor_in = 1'b0;
        start = 1'b1; mode_sel = 2'd1;
        @(negedge clk27);
        start = 1'b0;
        for (int k = 1; k <= 8000; k++) begin
            @(negedge clk27);
            if (lt_active && !prev_act) begin n_rise++; t0 = k; end
            prev_act = lt_active;
            if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
            if (done_k >= 0 && k >= done_k + 3) break;
            if (t0 >= 0 && n_rise >= 1 && n_rise <= 4) begin
                if (k - t0 == ds[n_rise-1]) sensor_in = 1'b1;
                else if (k - t0 == ds[n_rise-1] + 2) sensor_in = 1'b0;
            end
        end
        total++; if (n_rise != 4) begin bad++; $display("FAIL avg_rounds got=%0d want=4", n_rise); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL avg_done_pulses got=%0d want=1", done_cnt); end
        total++; if (latency !== exp_l) begin bad++; $display("FAIL avg_latency got=%0d want=%0d", latency, exp_l); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL avg_timeout got=%b want=0", timeout); end
    endtask
`endif

    initial begin
        test_reset;
`ifdef LT_AVG_EN
        test_avg;
        test_reset_mid;
`else
        test_basic;
        test_random;
        test_boundary;
        test_timeout;
        test_bad_start;
        test_skip_lit_frame;
        test_release_toggle;
        test_reset_mid;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
